// File: rtl/otp_stream_cipher.sv
// One-time-pad engine: append-only pad memory with independent encrypt and
// decrypt consumption pointers, start/done handshake and a passthrough mode.
module otp_stream_cipher #(
    parameter int DATA_WIDTH = 8,
    parameter int PAD_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  passthrough,
    input  logic                  decrypt,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  done,
    output logic                  busy,
    output logic                  error,
    input  logic                  key_wr_en,
    input  logic [DATA_WIDTH-1:0] key_wr_data,
    input  logic                  key_clear,
    output logic                  pad_full,
    output logic                  enc_exhausted,
    output logic                  dec_exhausted
);

    localparam int PTR_W = $clog2(PAD_DEPTH + 1);
    localparam int IDX_W = $clog2(PAD_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(PAD_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_XOR  = 2'd2;

    logic [1:0]            state;
    logic [PTR_W-1:0]      wr_cnt;
    logic [PTR_W-1:0]      enc_ptr;
    logic [PTR_W-1:0]      dec_ptr;
    logic [PTR_W-1:0]      sel_ptr;
    logic [DATA_WIDTH-1:0] pad_mem [PAD_DEPTH];
    logic [DATA_WIDTH-1:0] pad_q;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_pass;
    logic                  lat_dec;
    logic                  lat_avail;
    logic                  clear_pending;
    logic                  idle;
    logic                  start_acc;
    logic                  wr_acc;

    assign pad_full      = (wr_cnt == DEPTH_CNT);
    assign enc_exhausted = (enc_ptr == wr_cnt);
    assign dec_exhausted = (dec_ptr == wr_cnt);
    assign busy          = (state == S_READ) || (state == S_XOR);

    // Accept decisions: clear beats start, start beats a pad write.
    always_comb begin
        idle      = (state == S_IDLE);
        sel_ptr   = decrypt ? dec_ptr : enc_ptr;
        start_acc = idle && start && !key_clear;
        wr_acc    = idle && key_wr_en && !key_clear && !start && !pad_full;
    end

    // Pad storage: append port plus a synchronous read issued on accepted start.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            pad_mem[wr_cnt[IDX_W-1:0]] <= key_wr_data;
        end
        if (start_acc && (sel_ptr < DEPTH_CNT)) begin
            pad_q <= pad_mem[sel_ptr[IDX_W-1:0]];
        end
    end

    // Control FSM, pointers and registered result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            output_data   <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            wr_cnt        <= '0;
            enc_ptr       <= '0;
            dec_ptr       <= '0;
            lat_data      <= '0;
            lat_pass      <= 1'b0;
            lat_dec       <= 1'b0;
            lat_avail     <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_clear) begin
                        wr_cnt      <= '0;
                        enc_ptr     <= '0;
                        dec_ptr     <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        output_data <= '0;
                    end else if (start_acc) begin
                        lat_data  <= input_data;
                        lat_pass  <= passthrough;
                        lat_dec   <= decrypt;
                        lat_avail <= (sel_ptr < wr_cnt);
                        done      <= 1'b0;
                        error     <= 1'b0;
                        state     <= S_READ;
                    end else if (wr_acc) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (key_clear) begin
                        clear_pending <= 1'b1;
                    end
                    state <= S_XOR;
                end
                S_XOR: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (lat_pass) begin
                        output_data <= lat_data;
                        error       <= 1'b0;
                    end else if (lat_avail) begin
                        output_data <= lat_data ^ pad_q;
                        error       <= 1'b0;
                        if (lat_dec) begin
                            dec_ptr <= dec_ptr + 1'b1;
                        end else begin
                            enc_ptr <= enc_ptr + 1'b1;
                        end
                    end else begin
                        output_data <= '0;
                        error       <= 1'b1;
                    end
                    // A clear seen while busy lands after the result; the later
                    // assignments override the pointer increment above.
                    if (clear_pending || key_clear) begin
                        wr_cnt        <= '0;
                        enc_ptr       <= '0;
                        dec_ptr       <= '0;
                        clear_pending <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Directed bench for otp_stream_cipher with hand-computed expected values.
module tb_otp_stream_cipher;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       passthrough;
    logic       decrypt;
    logic [7:0] input_data;
    logic [7:0] output_data;
    logic       done;
    logic       busy;
    logic       error;
    logic       key_wr_en;
    logic [7:0] key_wr_data;
    logic       key_clear;
    logic       pad_full;
    logic       enc_exhausted;
    logic       dec_exhausted;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    otp_stream_cipher #(
        .DATA_WIDTH(8),
        .PAD_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .passthrough  (passthrough),
        .decrypt      (decrypt),
        .input_data   (input_data),
        .output_data  (output_data),
        .done         (done),
        .busy         (busy),
        .error        (error),
        .key_wr_en    (key_wr_en),
        .key_wr_data  (key_wr_data),
        .key_clear    (key_clear),
        .pad_full     (pad_full),
        .enc_exhausted(enc_exhausted),
        .dec_exhausted(dec_exhausted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        key_wr_en   = 1'b1;
        key_wr_data = w;
        tick();
        key_wr_en   = 1'b0;
    endtask

    // Issue one operation and check the two-cycle latency handshake.
    task automatic op(input string tag, input logic pt, input logic dec, input logic [7:0] d,
                      input logic [7:0] exp_out, input logic exp_err);
        start       = 1'b1;
        passthrough = pt;
        decrypt     = dec;
        input_data  = d;
        tick();
        start = 1'b0;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        check({tag, "_done1"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done2"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out"}, 32'(output_data), 32'(exp_out));
        check({tag, "_err"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; passthrough = 1'b0; decrypt = 1'b0;
        input_data = '0; key_wr_en = 1'b0; key_wr_data = '0; key_clear = 1'b0;
        #50;
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_out", 32'(output_data), 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_full", 32'(pad_full), 32'd0);
        check("rst_encx", 32'(enc_exhausted), 32'd1);
        check("rst_decx", 32'(dec_exhausted), 32'd1);

        // Load two pads
        load(8'hA5);
        load(8'h3C);
        check("ld_wrcnt", 32'(dut.wr_cnt), 32'd2);
        check("ld_full", 32'(pad_full), 32'd0);
        check("ld_encx", 32'(enc_exhausted), 32'd0);
        check("ld_decx", 32'(dec_exhausted), 32'd0);

        // Encrypt / decrypt round trips
        op("enc1", 1'b0, 1'b0, 8'h33, 8'h96, 1'b0);
        op("dec1", 1'b0, 1'b1, 8'h96, 8'h33, 1'b0);
        op("enc2", 1'b0, 1'b0, 8'h27, 8'h1B, 1'b0);
        op("dec2", 1'b0, 1'b1, 8'h1B, 8'h27, 1'b0);
        check("rt_encx", 32'(enc_exhausted), 32'd1);
        check("rt_decx", 32'(dec_exhausted), 32'd1);

        // Exhausted encrypt, then passthrough
        op("enc_none", 1'b0, 1'b0, 8'h55, 8'h00, 1'b1);
        check("none_encptr", 32'(dut.enc_ptr), 32'd2);
        op("pass", 1'b1, 1'b0, 8'hDE, 8'hDE, 1'b0);
        check("pass_encptr", 32'(dut.enc_ptr), 32'd2);
        check("pass_decptr", 32'(dut.dec_ptr), 32'd2);

        // Clear in IDLE, fill to capacity, overflow write ignored
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("clr_wrcnt", 32'(dut.wr_cnt), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_out", 32'(output_data), 32'h0);
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        check("fill_full", 32'(pad_full), 32'd1);
        load(8'h55);
        check("ovf_wrcnt", 32'(dut.wr_cnt), 32'd4);
        check("ovf_full", 32'(pad_full), 32'd1);

        // start held through READ is ignored: exactly one operation
        start = 1'b1; passthrough = 1'b0; decrypt = 1'b0; input_data = 8'h0F;
        tick();
        tick();
        start = 1'b0;
        tick();
        check("hold_done", 32'(done), 32'd1);
        check("hold_out", 32'(output_data), 32'h1E);
        check("hold_encptr", 32'(dut.enc_ptr), 32'd1);
        tick(); tick();
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_encptr2", 32'(dut.enc_ptr), 32'd1);

        // start beats a simultaneous pad write
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        load(8'h5A);
        key_wr_en = 1'b1; key_wr_data = 8'h77;
        op("wr_vs_start", 1'b0, 1'b0, 8'hA0, 8'hFA, 1'b0);
        key_wr_en = 1'b0;
        check("wvs_wrcnt", 32'(dut.wr_cnt), 32'd1);

        // Clear during XOR: result completes, then pointers zero
        start = 1'b1; decrypt = 1'b1; input_data = 8'hFA;
        tick();
        start = 1'b0;
        tick();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("xclr_done", 32'(done), 32'd1);
        check("xclr_out", 32'(output_data), 32'hA0);
        check("xclr_err", 32'(error), 32'd0);
        check("xclr_wrcnt", 32'(dut.wr_cnt), 32'd0);
        check("xclr_encptr", 32'(dut.enc_ptr), 32'd0);
        check("xclr_decptr", 32'(dut.dec_ptr), 32'd0);
        op("after_clr", 1'b0, 1'b0, 8'h12, 8'h00, 1'b1);

        // Reset during READ aborts the operation
        load(8'h81);
        start = 1'b1; decrypt = 1'b0; input_data = 8'h01;
        tick();
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(output_data), 32'h0);
        check("abort_wrcnt", 32'(dut.wr_cnt), 32'd0);
        check("abort_ptrs", 32'({dut.enc_ptr, dut.dec_ptr}), 32'd0);
        reset = 1'b1;
        tick();
        load(8'h81);
        op("resume", 1'b0, 1'b0, 8'h01, 8'h80, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
